// File: rtl/ptw_req_arbiter_pkg.sv
// Shared TLB/PTW sizing constants plus small helpers for the walk-request arbiter.
package ptw_req_arbiter_pkg;

  localparam int PTW_REQ_NUM = 2;
  localparam int PADDR_SIZE  = 32;
  localparam int DCACHE_BANK = 4;
  localparam int DCACHE_BITS = 32;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rr_next(input int k, input int n);
    return (k + 1 >= n) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/ptw_req_arbiter_rr.sv
// Round-robin winner pick: search starts at ptr and wraps; purely combinational.
module RRArbiter
  import ptw_req_arbiter_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0]        req,
  input  logic [idx_w(WIDTH)-1:0] ptr,
  output logic [WIDTH-1:0]        grant,
  output logic [idx_w(WIDTH)-1:0] idx
);

  localparam int IW = idx_w(WIDTH);

  logic [WIDTH-1:0] rot;
  logic             found;
  int               pos;

  // rot[i] is the requester that sits i places after the pointer.
  always_comb begin
    rot   = WIDTH'({req, req} >> ptr);
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pos   = int'(ptr) + i;
        if (pos >= WIDTH) pos = pos - WIDTH;
        grant = WIDTH'(1) << pos;
        idx   = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/ptw_req_arbiter.sv
// Shares one cache read port among page-table walkers, one access in flight at a time.
// req_o follows a grant by one cycle; full_i replays in place, flush abandons the access.
module ptw_req_arbiter
  import ptw_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ = PTW_REQ_NUM,
  parameter int ADDR_W  = PADDR_SIZE,
  parameter int DATA_W  = DCACHE_BANK * DCACHE_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] paddr_i,
  output logic [NUM_REQ-1:0]        ready_o,
  output logic [NUM_REQ-1:0]        full_o,
  output logic [NUM_REQ-1:0]        data_valid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      req_o,
  output logic [ADDR_W-1:0]         paddr_o,
  input  logic                      ready_i,
  input  logic                      full_i,
  input  logic                      data_valid_i,
  input  logic [DATA_W-1:0]         rdata_i
);

  localparam int IW = idx_w(NUM_REQ);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t             state;
  logic [IW-1:0]      owner;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      win_idx;
  logic [NUM_REQ-1:0] win_grant;
  logic [NUM_REQ-1:0] owner_oh;
  logic [ADDR_W-1:0]  win_paddr;
  logic               stale_ok;

  RRArbiter #(.WIDTH(NUM_REQ)) u_rr (
    .req   (req_i),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx)
  );

  always_comb begin
    win_paddr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_grant[i]) win_paddr = paddr_i[i*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= '0;
      rr_ptr  <= '0;
      paddr_o <= '0;
      req_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush && |win_grant) begin
            owner   <= win_idx;
            paddr_o <= win_paddr;
            rr_ptr  <= IW'(rr_next(int'(win_idx), NUM_REQ));
            req_o   <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          // An accept coinciding with flush still owes the cache a response.
          if (flush) begin
            req_o <= 1'b0;
            state <= (ready_i && !full_i) ? DRAIN : IDLE;
          end else if (!full_i && ready_i) begin
            req_o <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (data_valid_i)  state <= IDLE;
          else if (flush)    state <= DRAIN;
        end
        DRAIN: begin
          if (data_valid_i)  state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign owner_oh = NUM_REQ'(1) << owner;
  assign rdata_o  = rdata_i;

  always_comb begin
    ready_o      = '0;
    full_o       = '0;
    data_valid_o = '0;
    if (state == REQ && !flush) begin
      if (full_i)       full_o  = owner_oh;
      else if (ready_i) ready_o = owner_oh;
    end
    if (state == WAIT && data_valid_i && !flush) data_valid_o = owner_oh;
  end

  // One response may still trail an access that reset cut short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               stale_ok <= 1'b1;
    else if (data_valid_i) stale_ok <= 1'b0;
  end

  assert property (@(posedge clk) disable iff (rst)
    (data_valid_i && (state == IDLE || state == REQ)) |-> stale_ok);

endmodule

// File: tb/tb_ptw_req_arbiter.sv
// Directed scoreboard bench for ptw_req_arbiter (2-way instance plus a 3-way wrap instance).
module tb_ptw_req_arbiter;

  localparam int K_GRANT = 0;
  localparam int K_READY = 1;
  localparam int K_FULL  = 2;
  localparam int K_DV    = 3;

  localparam logic [31:0]  A0 = 32'h1000_0040;
  localparam logic [31:0]  A1 = 32'h2000_0080;
  localparam logic [127:0] D0 = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
  localparam logic [127:0] D1 = 128'hfeed_0001_feed_0002_feed_0003_feed_0004;
  localparam logic [127:0] D2 = 128'h5555_aaaa_5555_aaaa_5555_aaaa_5555_aaaa;
  localparam logic [127:0] D3 = 128'h0bad_0bad_0bad_0bad_0bad_0bad_0bad_0bad;

  typedef struct {
    int           kind;
    logic [2:0]   mask;
    logic [127:0] val;
  } ev_t;

  ev_t         q[$];
  logic [31:0] q3[$];
  int          total = 0;
  int          bad = 0;
  int          req_hi_cnt = 0;
  int          snap;
  logic        req_prev = 1'b0;
  logic        req3_prev = 1'b0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [1:0]   req = 2'b11;
  logic [31:0]  pa0 = A0;
  logic [31:0]  pa1 = A1;
  logic [63:0]  paddr;
  logic [1:0]   ready_o, full_o, data_valid_o;
  logic [127:0] rdata_o;
  logic         req_o;
  logic [31:0]  paddr_o;
  logic         rdy = 1'b0;
  logic         full = 1'b0;
  logic         dv = 1'b0;
  logic [127:0] rdata = '0;

  logic         rst3 = 1'b1;
  logic [2:0]   req3 = 3'b111;
  logic [95:0]  paddr3 = {32'h3000_0300, 32'h3000_0200, 32'h3000_0100};
  logic [2:0]   ready_o3, full_o3, data_valid_o3;
  logic [127:0] rdata_o3;
  logic         req_o3;
  logic [31:0]  paddr_o3;
  logic         dv3 = 1'b0;

  assign paddr = {pa1, pa0};

  always #5 clk = ~clk;

  ptw_req_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush), .req_i(req), .paddr_i(paddr),
    .ready_o(ready_o), .full_o(full_o), .data_valid_o(data_valid_o), .rdata_o(rdata_o),
    .req_o(req_o), .paddr_o(paddr_o), .ready_i(rdy), .full_i(full),
    .data_valid_i(dv), .rdata_i(rdata)
  );

  ptw_req_arbiter #(.NUM_REQ(3)) dut3 (
    .clk(clk), .rst(rst3), .flush(1'b0), .req_i(req3), .paddr_i(paddr3),
    .ready_o(ready_o3), .full_o(full_o3), .data_valid_o(data_valid_o3), .rdata_o(rdata_o3),
    .req_o(req_o3), .paddr_o(paddr_o3), .ready_i(1'b1), .full_i(1'b0),
    .data_valid_i(dv3), .rdata_i(128'd0)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [2:0] mask, input logic [127:0] val);
    ev_t e;
    e.kind = kind;
    e.mask = mask;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_ev(input int kind, input logic [2:0] mask, input logic [127:0] val);
    ev_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event at %0t: got kind=%0d mask=%b val=%h want none", $time, kind, mask, val);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.mask !== mask || e.val !== val) begin
        bad++;
        $display("FAIL event at %0t: got kind=%0d mask=%b val=%h want kind=%0d mask=%b val=%h",
                 $time, kind, mask, val, e.kind, e.mask, e.val);
      end
    end
  endtask

  // Monitor: every observable output event is matched against the scoreboard queues.
  always @(negedge clk) begin
    if (rst) begin
      req_prev = 1'b0;
    end else begin
      if (req_o && !req_prev)  check_ev(K_GRANT, 3'b000, {96'd0, paddr_o});
      if (|ready_o)            check_ev(K_READY, {1'b0, ready_o}, 128'd0);
      if (|full_o)             check_ev(K_FULL, {1'b0, full_o}, 128'd0);
      if (|data_valid_o)       check_ev(K_DV, {1'b0, data_valid_o}, rdata_o);
      req_prev = req_o;
      if (req_o) req_hi_cnt++;
    end
    if (rst3) begin
      req3_prev = 1'b0;
    end else begin
      if (req_o3 && !req3_prev) begin
        total++;
        if (q3.size() == 0) begin
          bad++;
          $display("FAIL wrap_grant: got %h want none", paddr_o3);
        end else if (paddr_o3 !== q3[0]) begin
          bad++;
          $display("FAIL wrap_grant: got %h want %h", paddr_o3, q3[0]);
          void'(q3.pop_front());
        end else begin
          void'(q3.pop_front());
        end
      end
      req3_prev = req_o3;
    end
  end

  initial begin
    // Reset state with both requesters already asking.
    repeat (2) @(negedge clk);
    chk("rst_req_o", {127'd0, req_o}, 128'd0);
    chk("rst_ready_o", {126'd0, ready_o}, 128'd0);
    chk("rst_full_o", {126'd0, full_o}, 128'd0);
    chk("rst_dv_o", {126'd0, data_valid_o}, 128'd0);
    chk("rst_paddr_o", {96'd0, paddr_o}, 128'd0);

    // Three-way wrap: IDLE, REQ (ready), WAIT (data) per grant.
    for (int i = 0; i < 6; i++) q3.push_back(paddr3[(i % 3)*32 +: 32]);
    cyc();
    rst3 = 1'b0;
    for (int t = 0; t < 18; t++) begin
      dv3 = (t % 3 == 2);
      cyc();
    end
    dv3  = 1'b0;
    req3 = 3'b000;
    repeat (3) cyc();
    chk("wrap_all_grants_seen", 128'(q3.size()), 128'd0);

    // C0: simultaneous request at reset exit, requester 0 first.
    rst = 1'b0;
    push(K_GRANT, 3'b000, {96'd0, A0});
    cyc();                                          // C1 REQ
    rdy = 1'b1; pa0 = 32'h0bad_f00d;
    push(K_READY, 3'b001, 128'd0);
    cyc();                                          // C2 WAIT
    rdy = 1'b0; req = 2'b10;
    cyc();                                          // C3 data
    dv = 1'b1; rdata = D0;
    push(K_DV, 3'b001, D0);
    cyc();                                          // C4 IDLE, grant 1
    dv = 1'b0;
    push(K_GRANT, 3'b000, {96'd0, A1});
    #2 chk("c4_req_o_low", {127'd0, req_o}, 128'd0);
    cyc();                                          // C5 REQ owner 1, replay
    #2 chk("c5_req_o", {127'd0, req_o}, 128'd1);
    chk("c5_paddr_o", {96'd0, paddr_o}, {96'd0, A1});
    snap = req_hi_cnt;
    full = 1'b1;
    push(K_FULL, 3'b010, 128'd0);
    cyc();                                          // C6
    pa1 = 32'hdead_beef; req = 2'b00;
    push(K_FULL, 3'b010, 128'd0);
    cyc();                                          // C7
    push(K_FULL, 3'b010, 128'd0);
    cyc();                                          // C8 accept
    full = 1'b0; rdy = 1'b1;
    push(K_READY, 3'b010, 128'd0);
    #2 chk("replay_paddr_held", {96'd0, paddr_o}, {96'd0, A1});
    cyc();                                          // C9 WAIT
    rdy = 1'b0;
    chk("replay_req_o_cycles", 128'(req_hi_cnt - snap), 128'd4);
    cyc();                                          // C10 data to owner 1
    dv = 1'b1; rdata = D1;
    push(K_DV, 3'b010, D1);
    cyc();                                          // C11 IDLE
    dv = 1'b0; req = 2'b01; pa0 = A0;
    push(K_GRANT, 3'b000, {96'd0, A0});
    cyc();                                          // C12 REQ
    rdy = 1'b1;
    push(K_READY, 3'b001, 128'd0);
    cyc();                                          // C13 WAIT + flush
    rdy = 1'b0; flush = 1'b1;
    snap = req_hi_cnt;
    cyc();                                          // C14 DRAIN
    flush = 1'b0;
    repeat (4) cyc();                               // C18 late data
    dv = 1'b1; rdata = D2;
    cyc();                                          // C19 IDLE
    dv = 1'b0;
    chk("drain_req_o_quiet", 128'(req_hi_cnt - snap), 128'd0);
    push(K_GRANT, 3'b000, {96'd0, A0});
    cyc();                                          // C20 REQ
    rdy = 1'b1;
    push(K_READY, 3'b001, 128'd0);
    cyc();                                          // C21 WAIT: flush with data
    rdy = 1'b0; flush = 1'b1; dv = 1'b1; rdata = D2; req = 2'b10; pa1 = A1;
    cyc();                                          // C22 IDLE with flush: no grant
    dv = 1'b0;
    cyc();                                          // C23
    flush = 1'b0;
    #2 chk("flush_idle_no_grant", {127'd0, req_o}, 128'd0);
    push(K_GRANT, 3'b000, {96'd0, A1});
    cyc();                                          // C24 REQ, flush without accept
    flush = 1'b1;
    cyc();                                          // C25 IDLE
    flush = 1'b0;
    #2 chk("flush_req_drop", {127'd0, req_o}, 128'd0);
    push(K_GRANT, 3'b000, {96'd0, A1});
    cyc();                                          // C26 REQ, flush with accept
    flush = 1'b1; rdy = 1'b1;
    cyc();                                          // C27 DRAIN, flush again
    rdy = 1'b0;
    cyc();                                          // C28
    flush = 1'b0;
    cyc();                                          // C29 data ends drain
    dv = 1'b1; rdata = D3;
    cyc();                                          // C30 IDLE
    dv = 1'b0;
    push(K_GRANT, 3'b000, {96'd0, A1});
    cyc();                                          // C31 REQ
    rdy = 1'b1;
    push(K_READY, 3'b010, 128'd0);
    cyc();                                          // C32 WAIT, then async reset
    rdy = 1'b0; req = 2'b00; dv = 1'b1; rdata = D3;
    #1 chk("pre_rst_dv_o", {126'd0, data_valid_o}, 128'd2);
    rst = 1'b1;
    #1 chk("async_rst_dv_o", {126'd0, data_valid_o}, 128'd0);
    chk("async_rst_req_o", {127'd0, req_o}, 128'd0);
    cyc();                                          // C33
    dv = 1'b0;
    #1 rst = 1'b0;
    cyc();                                          // C34 stale data in IDLE
    dv = 1'b1;
    cyc();
    dv = 1'b0;
    repeat (3) cyc();
    chk("scoreboard_drained", 128'(q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
